// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-client ALU request scheduler:
// unit and sub-op codes, FSM state encoding and response flag layout.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b0001;
    localparam logic [3:0] OP_LOGIC = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;

    localparam logic [3:0] SUB_ADD_ADD = 4'b0000;
    localparam logic [3:0] SUB_ADD_SUB = 4'b0001;
    localparam logic [3:0] SUB_SH_SLL  = 4'b0000;
    localparam logic [3:0] SUB_SH_SRL  = 4'b0001;
    localparam logic [3:0] SUB_SH_SRA  = 4'b0010;
    localparam logic [3:0] SUB_SH_LUI  = 4'b0011;
    localparam logic [3:0] SUB_LG_AND  = 4'b0000;
    localparam logic [3:0] SUB_LG_OR   = 4'b0001;
    localparam logic [3:0] SUB_LG_XOR  = 4'b0010;
    localparam logic [3:0] SUB_LG_NOR  = 4'b0011;
    localparam logic [3:0] SUB_MAX     = 4'b0011;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op, input logic [3:0] op1);
        return (op <= OP_MUL) && (op1 <= SUB_MAX);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the other client each
// time a response completes, so a persistent requester cannot starve its peer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_done,
    input  logic       i_owner,
    output logic       o_gnt_valid,
    output logic       o_gnt
);

    logic r_ptr;

    // Priority pointer, flipped away from the client just served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_done) begin
            r_ptr <= ~i_owner;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt_valid = |i_valid;
    assign o_gnt       = i_valid[r_ptr] ? r_ptr : ~r_ptr;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters: accepts one request at
// a time, holds the operands for the unit settle time, returns the captured result.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_WAIT = 1,
    parameter int MUL_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req0_op1,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [3:0]  req1_op1,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_data,
    output logic [3:0]  rsp0_flags,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_data,
    output logic [3:0]  rsp1_flags,
    output logic        rsp1_err,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_op1,
    output logic [31:0] alu_in0,
    output logic [31:0] alu_in1,
    input  logic [63:0] alu_out,
    input  logic        alu_carryout,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    input  logic        alu_N
);

    localparam logic [CNT_W-1:0] LD_ALU = CNT_W'(ALU_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(MUL_WAIT - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_alu_op;
    logic [3:0]        r_alu_op1;
    logic [31:0]       r_alu_in0;
    logic [31:0]       r_alu_in1;
    logic [63:0]       r_data;
    logic [3:0]        r_flags;
    logic              r_err;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;

    logic              w_gnt_valid;
    logic              w_gnt;
    logic              w_accept;
    logic              w_capture;
    logic              w_done;
    logic              w_legal;
    logic              w_rsp_hs;
    logic [3:0]        w_sel_op;
    logic [3:0]        w_sel_op1;
    logic [31:0]       w_sel_a;
    logic [31:0]       w_sel_b;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     ({req1_valid, req0_valid}),
        .i_done      (w_done),
        .i_owner     (r_owner),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    assign w_sel_op  = w_gnt ? req1_op  : req0_op;
    assign w_sel_op1 = w_gnt ? req1_op1 : req0_op1;
    assign w_sel_a   = w_gnt ? req1_a   : req0_a;
    assign w_sel_b   = w_gnt ? req1_b   : req0_b;
    assign w_legal   = op_legal(w_sel_op, w_sel_op1);
    assign w_rsp_hs  = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = w_legal ? ST_EXEC : ST_RESP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand latch, settle counter and result capture; illegal ops leave the ALU bus untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_alu_op  <= 4'd0;
            r_alu_op1 <= 4'd0;
            r_alu_in0 <= 32'd0;
            r_alu_in1 <= 32'd0;
            r_data    <= 64'd0;
            r_flags   <= 4'd0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_gnt;
            if (w_legal) begin
                r_alu_op  <= w_sel_op;
                r_alu_op1 <= w_sel_op1;
                r_alu_in0 <= w_sel_a;
                r_alu_in1 <= w_sel_b;
                r_cnt     <= (w_sel_op == OP_MUL) ? LD_MUL : LD_ALU;
                r_err     <= 1'b0;
            end else begin
                r_data  <= 64'd0;
                r_flags <= 4'd0;
                r_err   <= 1'b1;
            end
        end else if (w_capture) begin
            r_data  <= (r_alu_op == OP_MUL) ? alu_out : {32'd0, alu_out[31:0]};
            r_flags <= {alu_N, alu_zero, alu_overflow, alu_carryout};
            r_err   <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Response valid, raised only toward the owner and dropped on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_rsp0_valid <= ~w_gnt;
            r_rsp1_valid <= w_gnt;
        end else if (w_capture) begin
            r_rsp0_valid <= ~r_owner;
            r_rsp1_valid <= r_owner;
        end else if (w_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end
    end

    assign req0_ready = w_accept & ~w_gnt;
    assign req1_ready = w_accept & w_gnt;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_data;
    assign rsp1_data  = r_data;
    assign rsp0_flags = r_flags;
    assign rsp1_flags = r_flags;
    assign rsp0_err   = r_err;
    assign rsp1_err   = r_err;
    assign alu_op     = r_alu_op;
    assign alu_op1    = r_alu_op1;
    assign alu_in0    = r_alu_in0;
    assign alu_in1    = r_alu_in1;

endmodule
